// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Definitions shared by the RV32I front end:
//   - XLEN_DEFAULT : default datapath / PC width
//   - OPC_*        : 7-bit major opcodes recognised by the decoder
//   - fetch_state_e: fetch FSM state encoding (3 bits)
//   - dec_flags_t  : one-hot instruction class flags plus the illegal marker
//   - opcode_of()  : extracts the major opcode field from an instruction word
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic r_type;
        logic i_type;
        logic store;
        logic branch;
        logic load;
        logic jal;
        logic jalr;
        logic auipc;
        logic lui;
        logic illegal;
    } dec_flags_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/inst_fetch_decode_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_decode_if
// Bundles every non-clock/reset signal of the fetch/decode front end.
//   imem_req_*      : fetch request channel (valid/ready, address)
//   imem_rsp_*      : instruction word return channel (valid, data)
//   dec_*           : decoded instruction presented to the control stage
//   r_type..illegal : one-hot instruction class flags
//   redirect_*      : PC redirect from branch/jump resolution
// Modports:
//   master : the fetch/decode block
//   slave  : its environment (instruction memory, control stage, resolver)
// -----------------------------------------------------------------------------
interface inst_fetch_decode_if #(
    parameter int XLEN = 32
);

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [31:0]     dec_instr;
    logic            r_type;
    logic            i_type;
    logic            store;
    logic            branch;
    logic            load;
    logic            jal;
    logic            jalr;
    logic            auipc;
    logic            lui;
    logic            illegal;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_pc, dec_instr,
        output r_type, i_type, store, branch, load, jal, jalr, auipc, lui, illegal,
        input  dec_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_pc, dec_instr,
        input  r_type, i_type, store, branch, load, jal, jalr, auipc, lui, illegal,
        output dec_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/opcode_decoder.sv
// -----------------------------------------------------------------------------
// opcode_decoder
// Purely combinational RV32I major-opcode classifier.
//   opcode : in  7  instruction bits [6:0]
//   flags  : out    exactly one class flag set, or only illegal set when the
//                   opcode is not one of the nine supported classes
// -----------------------------------------------------------------------------
module opcode_decoder
    import rv32_pkg::*;
(
    input  logic [6:0] opcode,
    output dec_flags_t flags
);

    always_comb begin
        flags = '0;
        case (opcode)
            OPC_OP:     flags.r_type  = 1'b1;
            OPC_OP_IMM: flags.i_type  = 1'b1;
            OPC_LOAD:   flags.load    = 1'b1;
            OPC_STORE:  flags.store   = 1'b1;
            OPC_BRANCH: flags.branch  = 1'b1;
            OPC_JAL:    flags.jal     = 1'b1;
            OPC_JALR:   flags.jalr    = 1'b1;
            OPC_AUIPC:  flags.auipc   = 1'b1;
            OPC_LUI:    flags.lui     = 1'b1;
            default:    flags.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_fetch_decode.sv
// -----------------------------------------------------------------------------
// inst_fetch_decode
// RV32I front end: fetches one instruction at a time from instruction memory,
// classifies its opcode and holds the decoded result until the control stage
// takes it. Branch/jump resolution can redirect the PC at any time.
// Parameters:
//   XLEN     : datapath / PC width
//   RESET_PC : PC loaded on reset (4-byte aligned)
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : inst_fetch_decode_if.master (imem request/response, decoded output,
//         class flags, redirect)
// -----------------------------------------------------------------------------
module inst_fetch_decode
    import rv32_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_decode_if.master bus
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            dec_valid_reg, dec_valid_next;
    logic [XLEN-1:0] dec_pc_reg, dec_pc_next;
    logic [31:0]     dec_instr_reg, dec_instr_next;
    dec_flags_t      flags_reg, flags_next;

    dec_flags_t      decoded_flags;
    logic [XLEN-1:0] redirect_target;

    opcode_decoder u_opcode_decoder (
        .opcode (opcode_of(bus.imem_rsp_data)),
        .flags  (decoded_flags)
    );

    assign redirect_target = bus.redirect_pc & ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= RESET_PC;
            dec_valid_reg <= 1'b0;
            dec_pc_reg    <= '0;
            dec_instr_reg <= '0;
            flags_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            dec_valid_reg <= dec_valid_next;
            dec_pc_reg    <= dec_pc_next;
            dec_instr_reg <= dec_instr_next;
            flags_reg     <= flags_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        dec_valid_next = dec_valid_reg;
        dec_pc_next    = dec_pc_reg;
        dec_instr_next = dec_instr_reg;
        flags_next     = flags_reg;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                if (bus.imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_next     = ST_HOLD;
                    dec_valid_next = 1'b1;
                    dec_pc_next    = pc_reg;
                    dec_instr_next = bus.imem_rsp_data;
                    flags_next     = decoded_flags;
                end
            end
            ST_HOLD: begin
                if (bus.dec_ready) begin
                    state_next     = ST_REQ;
                    pc_next        = pc_reg + PC_STEP;
                    dec_valid_next = 1'b0;
                end
            end
            ST_DRAIN: begin
                // The flushed request's word is thrown away when it arrives.
                if (bus.imem_rsp_valid) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Redirect overrides everything above, including a HOLD consume, so
        // the PC lands exactly on the target. The next state depends on
        // whether an imem response is still owed to us.
        if (bus.redirect_valid) begin
            pc_next        = redirect_target;
            dec_valid_next = 1'b0;
            dec_pc_next    = dec_pc_reg;
            dec_instr_next = dec_instr_reg;
            flags_next     = flags_reg;
            case (state_reg)
                ST_WAIT, ST_DRAIN: begin
                    state_next = bus.imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end
                ST_REQ: begin
                    state_next = bus.imem_req_ready ? ST_DRAIN : ST_REQ;
                end
                default: begin
                    state_next = ST_REQ;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = (state_reg == ST_REQ);
    assign bus.imem_req_addr  = pc_reg;

    assign bus.dec_valid = dec_valid_reg;
    assign bus.dec_pc    = dec_pc_reg;
    assign bus.dec_instr = dec_instr_reg;
    assign bus.r_type    = flags_reg.r_type;
    assign bus.i_type    = flags_reg.i_type;
    assign bus.store     = flags_reg.store;
    assign bus.branch    = flags_reg.branch;
    assign bus.load      = flags_reg.load;
    assign bus.jal       = flags_reg.jal;
    assign bus.jalr      = flags_reg.jalr;
    assign bus.auipc     = flags_reg.auipc;
    assign bus.lui       = flags_reg.lui;
    assign bus.illegal   = flags_reg.illegal;

endmodule
